// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the divider: FSM encodings, iteration count and
// a sign-magnitude helper used when latching operands.
package div_unit_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  // Magnitude of a 32-bit operand; only folded when the op is signed.
  function automatic logic [31:0] div_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) feeding the HI/LO register:
// one quotient bit per cycle on magnitudes, sign fix-up on completion.
module div_unit #(
  parameter int DIV_CYCLES = div_unit_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        ready,
  output logic        busy
);
  import div_unit_pkg::*;

  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [64:0] work_q;
  logic [31:0] dvsr_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] result_hi_q;
  logic [31:0] result_lo_q;

  logic [64:0] shifted;
  logic [32:0] diff;
  logic [64:0] step_d;
  logic [31:0] quo_d;
  logic [31:0] rem_d;
  logic        last_step;

  // Working register: [63:32] partial remainder, [31:0] dividend bits
  // shifting out the top while quotient bits shift in at the bottom.
  always_comb begin
    shifted   = {work_q[63:0], 1'b0};
    diff      = shifted[64:32] - {1'b0, dvsr_q};
    step_d    = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};
    quo_d     = neg_quo_q ? (~step_d[31:0] + 32'd1) : step_d[31:0];
    rem_d     = neg_rem_q ? (~step_d[63:32] + 32'd1) : step_d[63:32];
    last_step = (cnt_q == CW'(DIV_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_hi_q <= '0;
      result_lo_q <= '0;
    end else if (annul) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            work_q    <= {33'b0, div_abs(opdata1, signed_div)};
            dvsr_q    <= div_abs(opdata2, signed_div);
            neg_quo_q <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_rem_q <= signed_div & opdata1[31];
            cnt_q     <= '0;
            state_q   <= (opdata2 == 32'd0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: begin
          result_hi_q <= '0;
          result_lo_q <= '0;
          state_q     <= DIV_END;
        end
        DIV_ON: begin
          work_q <= step_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_step) begin
            result_hi_q <= rem_d;
            result_lo_q <= quo_d;
            state_q     <= DIV_END;
          end
        end
        DIV_END: state_q <= DIV_IDLE;
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == DIV_ON) || (state_q == DIV_BYZERO);
  assign ready     = (state_q == DIV_END);
  assign result_hi = result_hi_q;
  assign result_lo = result_lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table of divisions plus hand-written
// sequences for back-to-back, ignored start, annul and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_unit #(.DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result_hi  (result_hi),
    .result_lo  (result_lo),
    .ready      (ready),
    .busy       (busy)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for one edge; returns #1 after that accepting edge.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    tick();
    start      = 1'b0;
    opdata1    = 32'hDEAD_BEEF;
    opdata2    = 32'h0BAD_F00D;
  endtask

  // Counts remaining busy cycles, then checks the completion cycle and the
  // return to idle. Leaves time in the IDLE cycle after END.
  task automatic wait_done(input string name, input int exp_cyc,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk({name, " busy_cycles"}, 32'(n), 32'(exp_cyc));
    chk({name, " ready"}, {31'b0, ready}, 32'd1);
    chk({name, " lo"}, result_lo, exp_lo);
    chk({name, " hi"}, result_hi, exp_hi);
    tick();
    chk({name, " ready_pulse"}, {31'b0, ready}, 32'd0);
  endtask

  initial begin
    int seen;

    vecs[0] = '{"u100_7",     1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        32};
    vecs[1] = '{"s-7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32};
    vecs[2] = '{"u-7_2",      1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        32};
    vecs[3] = '{"div0",       1'b0, 32'h12345678, 32'd0,        32'd0,        32'd0,        1};
    vecs[4] = '{"s_min_neg1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32};
    vecs[5] = '{"u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        32};
    vecs[6] = '{"s7_-2",      1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        32};
    vecs[7] = '{"s-7_-2",     1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32};
    vecs[8] = '{"u5_10",      1'b0, 32'd5,        32'd10,       32'd0,        32'd5,        32};
    vecs[9] = '{"s_div0",     1'b1, 32'h80000000, 32'd0,        32'd0,        32'd0,        1};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    tick(); tick();
    chk("reset busy",  {31'b0, busy},  32'd0);
    chk("reset ready", {31'b0, ready}, 32'd0);
    chk("reset lo", result_lo, 32'd0);
    chk("reset hi", result_hi, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].cyc, vecs[i].lo, vecs[i].hi);
    end

    // Start during END is dropped; the following IDLE cycle accepts it.
    issue(1'b0, 32'd100, 32'd7);
    seen = 0;
    while (busy === 1'b1 && seen < 100) begin seen++; tick(); end
    chk("b2b first ready", {31'b0, ready}, 32'd1);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
    tick();
    chk("start_in_end ignored", {31'b0, busy}, 32'd0);
    issue(1'b0, 32'd50, 32'd5);
    wait_done("b2b 50_5", 32, 32'd10, 32'd0);

    // Start pulsed while busy must not disturb the operands in flight.
    issue(1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 5; k++) tick();
    start = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    tick();
    start = 1'b0;
    wait_done("start_while_busy", 26, 32'd14, 32'd2);

    // Annul ten cycles in: no ready, results keep 14/2.
    issue(1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    chk("annul busy", {31'b0, busy}, 32'd0);
    tick();
    issue(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_done("after_annul s-100_7", 32, 32'hFFFFFFF2, 32'hFFFFFFFE);

    issue(1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    chk("annul no ready/busy", 32'(seen), 32'd0);
    chk("annul lo kept", result_lo, 32'hFFFFFFF2);
    chk("annul hi kept", result_hi, 32'hFFFFFFFE);

    // Annul beats start in IDLE.
    annul = 1'b1; start = 1'b1; opdata1 = 32'd9; opdata2 = 32'd3;
    tick();
    annul = 1'b0; start = 1'b0;
    chk("annul+start busy", {31'b0, busy}, 32'd0);
    tick();
    chk("annul+start ready", {31'b0, ready}, 32'd0);

    // Mid-operation reset clears everything and no ready follows.
    issue(1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1; annul = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; annul = 1'b0; start = 1'b0;
    chk("midrst busy",  {31'b0, busy},  32'd0);
    chk("midrst ready", {31'b0, ready}, 32'd0);
    chk("midrst lo", result_lo, 32'd0);
    chk("midrst hi", result_hi, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready === 1'b1) seen++;
      tick();
    end
    chk("midrst no ready", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
